// File: rtl/spi_flash_arb_pkg.sv
// Shared types and defaults for the SPI flash read arbiter.
package spi_flash_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  localparam int ADDR_W_DEFAULT = 24;

endpackage

// File: rtl/spi_rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr, wrapping.
module spi_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  localparam int unsigned N = NUM_REQ;

  always_comb begin
    int unsigned base;
    int unsigned k;
    logic [IDX_W-1:0] kk;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    base   = 32'(ptr);
    k      = 0;
    kk     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      k  = (base + i) % N;
      kk = IDX_W'(k);
      if (!any && req[kk]) begin
        any        = 1'b1;
        onehot[kk] = 1'b1;
        idx        = kk;
      end
    end
  end

endmodule

// File: rtl/spi_flash_arbiter.sv
// Round-robin arbiter sharing one SPI flash read controller among NUM_REQ requesters.
// Optional WAIT-state timeout is enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_flash_arbiter
  import spi_flash_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_W         = ADDR_W_DEFAULT,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
  output logic [NUM_REQ-1:0]        o_grant,
  output logic [NUM_REQ-1:0]        o_done,
  output logic [NUM_REQ-1:0]        o_err,
  output logic [ADDR_W-1:0]         o_read_addr,
  output logic                      o_read_stb,
  input  logic                      i_read_done_stb,
  output logic                      o_busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t             state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   next_ptr;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic [ADDR_W-1:0]  addr_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_addr
    assign addr_arr[g] = i_req_addr[g*ADDR_W +: ADDR_W];
  end

  spi_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req    (i_req),
    .ptr    (rr_ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign next_ptr = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0]   cnt;
  logic [NUM_REQ-1:0] err;
  assign o_err = err;
`else
  assign o_err = '0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= S_IDLE;
      rr_ptr      <= '0;
      owner       <= '0;
      o_grant     <= '0;
      o_done      <= '0;
      o_read_stb  <= 1'b0;
      o_read_addr <= '0;
      o_busy      <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
      cnt         <= '0;
      err         <= '0;
`endif
    end else begin
      o_read_stb <= 1'b0;
      o_done     <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      err        <= '0;
`endif
      case (state)
        S_IDLE: begin
          if (pick_any) begin
            // Strobe is registered here so it is visible in exactly the ISSUE cycle.
            owner       <= pick_idx;
            o_grant     <= pick_onehot;
            o_read_addr <= addr_arr[pick_idx];
            o_read_stb  <= 1'b1;
            o_busy      <= 1'b1;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
`ifdef SPI_ARB_TIMEOUT_EN
          cnt   <= '0;
`endif
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (i_read_done_stb) begin
            o_done <= o_grant;
            state  <= S_DONE;
          end
`ifdef SPI_ARB_TIMEOUT_EN
          else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            err   <= o_grant;
            state <= S_ERR;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        S_DONE, S_ERR: begin
          rr_ptr  <= next_ptr;
          o_grant <= '0;
          o_busy  <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Self-checking bench for spi_flash_arbiter: vector table, hand corner cases, randomized traffic.
module tb_spi_flash_arbiter;

  localparam int N  = 4;
  localparam int AW = 24;
`ifdef SPI_ARB_TIMEOUT_EN
  localparam int LONG_DELAY = 10;
`else
  localparam int LONG_DELAY = 20;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    grant, done, err;
  logic [AW-1:0]   read_addr;
  logic            read_stb, read_done_stb, busy;

  int n_vec  = 0;
  int n_fail = 0;
  int model_ptr = 0;
  logic [AW-1:0] taddr [N];

  typedef struct {
    logic [N-1:0] req;
    int           delay;
    int           owner;
  } vec_t;

  always #5 clk = ~clk;

  spi_flash_arbiter #(
    .NUM_REQ        (N),
    .ADDR_W         (AW),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_req           (req),
    .i_req_addr      (req_addr),
    .o_grant         (grant),
    .o_done          (done),
    .o_err           (err),
    .o_read_addr     (read_addr),
    .o_read_stb      (read_stb),
    .i_read_done_stb (read_done_stb),
    .o_busy          (busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic load_addr;
    for (int k = 0; k < N; k++) req_addr[k*AW +: AW] = taddr[k];
  endtask

  // Reference: rotate the doubled request vector by the pointer, take the lowest set bit.
  function automatic int pick_model(input logic [N-1:0] r, input int ptr);
    logic [2*N-1:0] rot;
    rot = {r, r} >> ptr;
    for (int p = 0; p < N; p++) if (rot[p]) return (ptr + p) % N;
    return -1;
  endfunction

  task automatic run_txn(input logic [N-1:0] r, input int delay, input int owner, input bit drop);
    logic [N-1:0] oh;
    oh = '0;
    oh[owner] = 1'b1;
    req = r;
    tick;
    check("grant", grant, oh);
    check("read_stb", read_stb, 1);
    check("read_addr", read_addr, taddr[owner]);
    check("busy", busy, 1);
    if (drop) req = '0;
    tick;
    check("stb_one_cycle", read_stb, 0);
    check("addr_hold", read_addr, taddr[owner]);
    check("grant_hold", grant, oh);
    for (int d = 0; d < delay; d++) begin
      tick;
      check("no_early_done", done, 0);
      check("wait_stb_low", read_stb, 0);
    end
    read_done_stb = 1'b1;
    tick;
    read_done_stb = 1'b0;
    check("done_pulse", done, oh);
    check("grant_in_done", grant, oh);
    check("no_err", err, 0);
    tick;
    check("done_one_cycle", done, 0);
    check("grant_clear", grant, 0);
    check("busy_clear", busy, 0);
    model_ptr = (owner + 1) % N;
  endtask

  initial begin
    vec_t tbl [11];
    int   waitc [N];
    logic [N-1:0] r;
    int   o;
    int   worst;

    tbl = '{
      '{4'b0010, LONG_DELAY, 1},
      '{4'b0001, 0, 0},
      '{4'b1000, 3, 3},
      '{4'b1111, 0, 0},
      '{4'b1111, 1, 1},
      '{4'b1111, 0, 2},
      '{4'b1111, 2, 3},
      '{4'b1111, 0, 0},
      '{4'b0101, 0, 2},
      '{4'b0101, 0, 0},
      '{4'b0110, 0, 1}
    };

    rst = 1'b1;
    req = '0;
    read_done_stb = 1'b0;
    taddr = '{24'h0AB000, 24'h001000, 24'h123456, 24'hFFFFFF};
    load_addr();
    tick;
    tick;
    check("rst_grant", grant, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_stb", read_stb, 0);
    check("rst_addr", read_addr, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    tick;
    check("idle_no_req", busy, 0);

    // Vector table: single request, then held contention showing rotation.
    for (int i = 0; i < 11; i++) run_txn(tbl[i].req, tbl[i].delay, tbl[i].owner, 1'b0);
    model_ptr = 2;

    // Owner drops its request mid-transaction; completion still reported.
    run_txn(4'b0100, 2, 2, 1'b1);

    // Done strobe outside WAIT is ignored.
    req = '0;
    read_done_stb = 1'b1;
    tick;
    read_done_stb = 1'b0;
    check("idle_done_ign_busy", busy, 0);
    check("idle_done_ign_done", done, 0);
    req = 4'b0001;
    tick;
    check("issue_grant", grant, 4'b0001);
    req = '0;
    read_done_stb = 1'b1;
    tick;
    read_done_stb = 1'b0;
    check("issue_done_ign_done", done, 0);
    tick;
    check("issue_done_ign_busy", busy, 1);
    check("issue_done_ign_done2", done, 0);
    read_done_stb = 1'b1;
    tick;
    read_done_stb = 1'b0;
    check("late_done", done, 4'b0001);
    tick;
    model_ptr = 1;

    // Mid-transaction reset abandons silently and restores pointer 0.
    run_txn(4'b0010, 0, 1, 1'b1);
    req = 4'b0100;
    tick;
    check("pre_rst_grant", grant, 4'b0100);
    req = '0;
    tick;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("mrst_grant", grant, 0);
    check("mrst_busy", busy, 0);
    check("mrst_addr", read_addr, 0);
    check("mrst_stb", read_stb, 0);
    tick;
    check("mrst_no_done", done, 0);
    check("mrst_no_err", err, 0);
    model_ptr = 0;
    run_txn(4'b1001, 1, pick_model(4'b1001, model_ptr), 1'b0);
    req = '0;

    // WAIT with no completion.
    req = 4'b1000;
    o = pick_model(req, model_ptr);
    tick;
    check("to_grant", grant, 4'b1000);
    req = '0;
    tick;
`ifdef SPI_ARB_TIMEOUT_EN
    for (int t = 1; t <= 16; t++) begin
      tick;
      if (t == 15) check("to_no_err_early", err, 0);
      if (t == 16) begin
        check("to_err_pulse", err, 4'b1000);
        check("to_no_done", done, 0);
      end
    end
    tick;
    check("to_err_one_cycle", err, 0);
    check("to_grant_clear", grant, 0);
    check("to_idle", busy, 0);
`else
    repeat (40) tick;
    check("wait_forever_busy", busy, 1);
    check("wait_forever_grant", grant, 4'b1000);
    check("wait_forever_err", err, 0);
    read_done_stb = 1'b1;
    tick;
    read_done_stb = 1'b0;
    check("wait_forever_done", done, 4'b1000);
    tick;
`endif
    model_ptr = (o + 1) % N;

    // Randomized traffic against the reference pointer model, with a fairness bound.
    for (int k = 0; k < N; k++) waitc[k] = 0;
    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < N; k++) taddr[k] = AW'($urandom);
      load_addr();
      r = N'($urandom_range(1, (1 << N) - 1));
      o = pick_model(r, model_ptr);
      worst = 0;
      for (int k = 0; k < N; k++) begin
        if (r[k] && k != o) waitc[k]++;
        else waitc[k] = 0;
        if (waitc[k] > worst) worst = waitc[k];
      end
      check("fairness", (worst <= N - 1), 1);
      run_txn(r, $urandom_range(0, 6), o, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
